stream_mux_nto1: RTL and testbench
==================================

Name: stream_mux_nto1

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer. Generalises the 2:1 select mux to NCH inputs with valid/ready handshake and a one-deep output register.
- Two selection modes, chosen at elaboration: external select or round-robin arbitration.
- Sits between multiple producers and a single downstream consumer in the datapath.

Parameters:
- WIDTH, 8, data width per channel in bits (>=1).
- NCH, 4, number of input channels (2..16).
- MODE, 0, 0 = external select via sel; 1 = round-robin arbitration (sel ignored).
- SELW (localparam), $clog2(NCH), width of sel, out_ch and the round-robin pointer.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- sel  input  SELW  channel select, used only when MODE=0.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_ch  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. Reset mid-transfer discards the held word. in_ready is all-zero while rst=1.
- load_en = !out_valid | out_ready. The output slot is free or emptying this cycle.
- Grant:
  - MODE=0: grant = sel when sel < NCH and in_valid[sel]=1. If sel >= NCH (non-power-of-2 NCH), nothing is granted.
  - MODE=1: grant = first i with in_valid[i]=1, searching from ptr upward with wrap (ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1). If no valid input, nothing is granted.
- in_ready[i] = load_en & (grant exists) & (grant == i). At most one bit is set per cycle.
  - MODE=0: in_ready[sel] may also be asserted when in_valid[sel]=0. It must not depend on in_valid; this avoids a valid/ready loop.
  - MODE=1: in_ready depends on in_valid through the arbiter; producers must not gate valid on ready.
- Transfer on channel i: in_valid[i] & in_ready[i]. On the next edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - MODE=1 only: ptr <= (i+1) mod NCH.
- No input transfer while load_en=1: out_valid <= out_valid & !out_ready, i.e. it clears when the held word is consumed.
- Stall (out_valid=1 & out_ready=0): out_data and out_ch are held stable; all in_ready=0.
- Simultaneous consume and load (out_valid=1, out_ready=1, input transfer): the new word replaces the old in the same edge; out_valid stays 1. This gives full throughput of 1 word/cycle.
- Latency: input transfer at edge k, visible on out_* after edge k, i.e. 1 cycle.
- out_ready -> in_ready is a combinational path by design. No bubble insertion is allowed.
- ptr is unchanged when no transfer occurs. sel may change every cycle; it is sampled only in the transfer cycle.
- Fairness (MODE=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NCH-1,0,...

Decomposition:
- Shared package stream_pkg holds the mode constants MUX_MODE_SEL=0 and MUX_MODE_RR=1.
- One natural sub-module: rr_arbiter (NCH parameter).
  - Inputs: req[NCH], ptr.
  - Outputs: gnt_valid, gnt_idx[SELW].
  - Purely combinational, instantiated only when MODE=1 via a generate.
- Output register and pointer update live in stream_mux_nto1.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately (async); after release the first grant goes to ch0 in MODE=1.
- MODE=0, WIDTH=8, NCH=4: sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> next cycle out_data=8'hA5, out_ch=2, out_valid=1; in_ready=4'b0100 during the transfer cycle.
- Backpressure: out_valid=1 holding 8'h3C, out_ready=0 for 3 cycles while sel and in_data change -> out_data stays 8'h3C, in_ready=0; on out_ready=1 the new word loads the same edge with no bubble.
- MODE=1 fairness: in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 at 1 word/cycle.
- MODE=1 sparse: in_valid=4'b1001 constant, ptr starting at 0 -> out_ch sequence 0,3,0,3; channels 1 and 2 never granted; in_valid=0 for one cycle -> out_valid drops after consume.
- NCH=3, MODE=0, sel=3 with in_valid=3'b111 -> in_ready=3'b000, out_valid falls to 0 once the last word is consumed.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream-datapath constants: selection modes for the N:1 stream mux.
package stream_pkg;

    // Channel chosen by the external sel input.
    localparam int MUX_MODE_SEL = 0;
    // Channel chosen by a rotating round-robin arbiter; sel is ignored.
    localparam int MUX_MODE_RR  = 1;

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel at or
// after ptr, wrapping around past the last channel.
module rr_arbiter #(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    // Scan ptr, ptr+1, ... with wrap and latch onto the first active request.
    always_comb begin
        int idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(ptr) + k) % NCH;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-channel registered stream multiplexer with valid/ready handshake and a
// one-deep output slot. Channel selection is either external (sel) or
// round-robin, fixed at elaboration by MODE.
module stream_mux_nto1
    import stream_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    parameter  int MODE  = MUX_MODE_SEL,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic            load_en;
    logic            gnt_valid;
    logic [SELW-1:0] gnt_idx;
    logic [SELW-1:0] ptr;
    logic            xfer;
    logic [WIDTH-1:0] gnt_data;

    // The output slot can accept a word when it is empty or being drained now.
    assign load_en = !out_valid || out_ready;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            // Round-robin grant; the external select has no role here.
            rr_arbiter #(
                .NCH (NCH)
            ) u_arb (
                .req       (in_valid),
                .ptr       (ptr),
                .gnt_valid (gnt_valid),
                .gnt_idx   (gnt_idx)
            );

            logic unused_sel;
            assign unused_sel = ^sel;
        end else begin : g_sel
            // External grant: deliberately independent of in_valid so that a
            // producer may wait for ready before raising valid. A sel beyond
            // the last channel (non power-of-two NCH) grants nothing.
            assign gnt_valid = (int'(sel) < NCH);
            assign gnt_idx   = sel;

            logic unused_ptr;
            assign unused_ptr = ^ptr;
        end
    endgenerate

    // One-hot ready towards the granted channel, forced low during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!rst && load_en && gnt_valid && (int'(gnt_idx) == i)) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Route the granted channel's word towards the output register.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(gnt_idx) == i) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output slot and round-robin pointer: load on transfer, clear on drain,
    // hold everything while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data  <= gnt_data;
                out_ch    <= gnt_idx;
                out_valid <= 1'b1;
                if (MODE == MUX_MODE_RR) begin
                    ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + SELW'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Testbench for stream_mux_nto1: three instances (select mode with 4 and 3
// channels, round-robin with 4 channels) checked through per-instance
// scoreboards plus direct checks of ready and reset behaviour.
module tb_stream_mux_nto1;
    import stream_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;

    logic [31:0] d0_in_data;
    logic [3:0]  d0_in_valid;
    logic [3:0]  d0_in_ready;
    logic [1:0]  d0_sel;
    logic [7:0]  d0_out_data;
    logic        d0_out_valid;
    logic        d0_out_ready;
    logic [1:0]  d0_out_ch;

    logic [31:0] d1_in_data;
    logic [3:0]  d1_in_valid;
    logic [3:0]  d1_in_ready;
    logic [1:0]  d1_sel;
    logic [7:0]  d1_out_data;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic [1:0]  d1_out_ch;

    logic [23:0] d2_in_data;
    logic [2:0]  d2_in_valid;
    logic [2:0]  d2_in_ready;
    logic [1:0]  d2_sel;
    logic [7:0]  d2_out_data;
    logic        d2_out_valid;
    logic        d2_out_ready;
    logic [1:0]  d2_out_ch;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    logic [1:0] stall_sel [3] = '{2'd3, 2'd0, 2'd2};

    stream_mux_nto1 #(.WIDTH(8), .NCH(4), .MODE(MUX_MODE_SEL)) dut0 (
        .clk(clk), .rst(rst), .in_data(d0_in_data), .in_valid(d0_in_valid),
        .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
        .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_ch(d0_out_ch)
    );

    stream_mux_nto1 #(.WIDTH(8), .NCH(4), .MODE(MUX_MODE_RR)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
        .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_ch(d1_out_ch)
    );

    stream_mux_nto1 #(.WIDTH(8), .NCH(3), .MODE(MUX_MODE_SEL)) dut2 (
        .clk(clk), .rst(rst), .in_data(d2_in_data), .in_valid(d2_in_valid),
        .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
        .out_valid(d2_out_valid), .out_ready(d2_out_ready), .out_ch(d2_out_ch)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic [3:0] valid,
                                 input logic [1:0] s, input logic rdy);
        case (which)
            0: begin d0_in_valid = valid;      d0_sel = s; d0_out_ready = rdy; end
            1: begin d1_in_valid = valid;      d1_sel = s; d1_out_ready = rdy; end
            default: begin d2_in_valid = valid[2:0]; d2_sel = s; d2_out_ready = rdy; end
        endcase
    endtask

    task automatic expectWord(input int which, input logic [1:0] ch, input logic [7:0] data);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        case (which)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic popCompare(input int which, input logic [1:0] ch, input logic [7:0] data);
        exp_t e;
        int   sz;
        case (which)
            0: sz = q0.size();
            1: sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d_unexpected_word: got ch=%0d data=0x%0h, expected no word",
                     which, ch, data);
        end else begin
            case (which)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            checkOutput($sformatf("dut%0d_word", which), {22'd0, ch, data}, {22'd0, e.ch, e.data});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word accepted downstream is compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst && d0_out_valid && d0_out_ready) popCompare(0, d0_out_ch, d0_out_data);
        if (!rst && d1_out_valid && d1_out_ready) popCompare(1, d1_out_ch, d1_out_data);
        if (!rst && d2_out_valid && d2_out_ready) popCompare(2, d2_out_ch, d2_out_data);
    end

    initial begin
        rst = 1'b1;
        d0_in_data = '0; d0_in_valid = '0; d0_sel = '0; d0_out_ready = 1'b1;
        d1_in_data = '0; d1_in_valid = '0; d1_sel = '0; d1_out_ready = 1'b0;
        d2_in_data = '0; d2_in_valid = '0; d2_sel = '0; d2_out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(d0_out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(d0_out_data), 32'd0);
        checkOutput("reset_out_ch", 32'(d0_out_ch), 32'd0);
        checkOutput("reset_in_ready", 32'(d0_in_ready), 32'd0);
        rst = 1'b0;
        step();

        // Select mode: single word from channel 2.
        d0_in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        applyStimulus(0, 4'b0100, 2'd2, 1'b1);
        #1;
        checkOutput("sel_in_ready", 32'(d0_in_ready), 32'h4);
        expectWord(0, 2'd2, 8'hA5);
        step();
        applyStimulus(0, 4'b0000, 2'd2, 1'b1);
        step();
        checkOutput("sel_drain_valid", 32'(d0_out_valid), 32'd0);

        // Backpressure: hold 3C for three stalled cycles while inputs churn.
        d0_in_data = {8'h44, 8'h33, 8'h3C, 8'h11};
        applyStimulus(0, 4'b0010, 2'd1, 1'b0);
        expectWord(0, 2'd1, 8'h3C);
        step();
        for (int k = 0; k < 3; k++) begin
            d0_in_data = {4{8'(8'h60 + k)}};
            applyStimulus(0, 4'b1111, stall_sel[k], 1'b0);
            #1;
            checkOutput($sformatf("stall%0d_in_ready", k), 32'(d0_in_ready), 32'd0);
            checkOutput($sformatf("stall%0d_out_data", k), 32'(d0_out_data), 32'h3C);
            checkOutput($sformatf("stall%0d_out_valid", k), 32'(d0_out_valid), 32'd1);
            step();
        end
        d0_in_data = {8'h5A, 8'h01, 8'h02, 8'h03};
        applyStimulus(0, 4'b1111, 2'd3, 1'b1);
        #1;
        checkOutput("unstall_in_ready", 32'(d0_in_ready), 32'h8);
        expectWord(0, 2'd3, 8'h5A);
        step();
        checkOutput("unstall_no_bubble", {23'd0, d0_out_valid, d0_out_data}, {23'd0, 1'b1, 8'h5A});
        applyStimulus(0, 4'b0000, 2'd3, 1'b1);
        step();
        checkOutput("unstall_drain_valid", 32'(d0_out_valid), 32'd0);

        // Round-robin fairness with every channel requesting.
        d1_in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        for (int k = 0; k < 8; k++) expectWord(1, 2'(k % 4), 8'(8'hC0 + (k % 4)));
        applyStimulus(1, 4'b1111, 2'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] exp_rdy;
            exp_rdy = 4'b0001 << (k % 4);
            #1;
            checkOutput($sformatf("rr_fair%0d_in_ready", k), 32'(d1_in_ready), 32'(exp_rdy));
            step();
        end
        applyStimulus(1, 4'b0000, 2'd0, 1'b1);
        step();
        checkOutput("rr_fair_drain_valid", 32'(d1_out_valid), 32'd0);

        // Round-robin with sparse requests on channels 0 and 3.
        applyStimulus(1, 4'b1001, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) expectWord(1, (k % 2 == 0) ? 2'd0 : 2'd3, (k % 2 == 0) ? 8'hC0 : 8'hC3);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput($sformatf("rr_sparse%0d_in_ready", k), 32'(d1_in_ready),
                        (k % 2 == 0) ? 32'h1 : 32'h8);
            step();
        end
        applyStimulus(1, 4'b0000, 2'd0, 1'b1);
        step();
        checkOutput("rr_sparse_drain_valid", 32'(d1_out_valid), 32'd0);

        // Reset while a word is held: discarded, pointer returns to channel 0.
        applyStimulus(1, 4'b0100, 2'd0, 1'b0);
        #1;
        checkOutput("rst_pre_in_ready", 32'(d1_in_ready), 32'h4);
        step();
        applyStimulus(1, 4'b0000, 2'd0, 1'b0);
        #1;
        checkOutput("rst_pre_held", {22'd0, d1_out_valid, d1_out_ch, d1_out_data},
                    {22'd0, 1'b1, 2'd2, 8'hC2});
        rst = 1'b1;
        #1;
        checkOutput("rst_async_out", {22'd0, d1_out_valid, d1_out_ch, d1_out_data}, 32'd0);
        applyStimulus(1, 4'b1111, 2'd0, 1'b1);
        #1;
        checkOutput("rst_async_in_ready", 32'(d1_in_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("rst_first_grant", 32'(d1_in_ready), 32'h1);
        expectWord(1, 2'd0, 8'hC0);
        step();
        applyStimulus(1, 4'b0000, 2'd0, 1'b1);
        step();
        checkOutput("rst_drain_valid", 32'(d1_out_valid), 32'd0);

        // Three channels: back-to-back words, then an out-of-range select.
        d2_in_data = {8'h33, 8'h32, 8'h31};
        applyStimulus(2, 4'b0111, 2'd0, 1'b1);
        #1;
        checkOutput("nch3_rdy0", 32'(d2_in_ready), 32'h1);
        expectWord(2, 2'd0, 8'h31);
        step();
        applyStimulus(2, 4'b0111, 2'd1, 1'b1);
        #1;
        checkOutput("nch3_rdy1", 32'(d2_in_ready), 32'h2);
        expectWord(2, 2'd1, 8'h32);
        step();
        applyStimulus(2, 4'b0111, 2'd2, 1'b1);
        #1;
        checkOutput("nch3_rdy2", 32'(d2_in_ready), 32'h4);
        expectWord(2, 2'd2, 8'h33);
        step();
        applyStimulus(2, 4'b0111, 2'd3, 1'b1);
        #1;
        checkOutput("nch3_sel3_in_ready", 32'(d2_in_ready), 32'd0);
        step();
        checkOutput("nch3_sel3_out_valid", 32'(d2_out_valid), 32'd0);
        step();
        checkOutput("nch3_sel3_idle", {29'd0, d2_out_valid, d2_in_ready[1:0]}, 32'd0);

        step();
        checkOutput("q0_empty", 32'(q0.size()), 32'd0);
        checkOutput("q1_empty", 32'(q1.size()), 32'd0);
        checkOutput("q2_empty", 32'(q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
